// File: rtl/hilo_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: FSM state encoding
// and the default datapath width.
package hilo_sequencer_pkg;

    localparam int HILO_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/hilo_sequencer.sv
// Issue-and-writeback stage around an external multi-cycle multiplier.
// Latches operands on a MULT request, pulses the multiplier start for one
// cycle, waits (bounded) for done and writes the product into HI/LO.
// MTHI/MTLO writes are accepted only while idle.
module hilo_sequencer
    import hilo_sequencer_pkg::*;
#(
    parameter int DATA_W  = HILO_DATA_W,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mult_req,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic                mthi_we,
    input  logic                mtlo_we,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                mult_ack,
    output logic                timeout_err,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    output logic                mul_start,
    input  logic [2*DATA_W-1:0] mul_result,
    input  logic                mul_done,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    // Last WAIT count value; the wait is abandoned when it is reached without done.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mul_a_q, mul_b_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                ack_q;
    logic                err_q;

    // mul_done is only meaningful in WAIT; a stale done seen in START is ignored.
    logic wait_done;
    logic wait_expire;
    assign wait_done   = (state_q == ST_WAIT) && mul_done;
    assign wait_expire = (state_q == ST_WAIT) && !mul_done && (cnt_q == CNT_LAST);

    // State register plus all datapath registers, synchronous active-high reset.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= wait_done;
            if (wait_expire) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // Moves to HI/LO land in the same cycle a request is accepted;
                    // the later product overwrites them.
                    if (mthi_we) hi_q <= wdata;
                    if (mtlo_we) lo_q <= wdata;
                    if (mult_req) begin
                        mul_a_q <= op_a;
                        mul_b_q <= op_b;
                    end
                end
                ST_START: begin
                    cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        {hi_q, lo_q} <= mul_result;
                    end else if (!wait_expire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mult_req) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (wait_done || wait_expire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        busy      = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_START: begin
                busy      = 1'b1;
                mul_start = 1'b1;
            end
            ST_WAIT:  busy = 1'b1;
            default:  ;
        endcase
    end

    assign mult_ack    = ack_q;
    assign timeout_err = err_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer with a behavioural 33-cycle multiplier
// whose done output can be held low to provoke the WAIT timeout.
module tb_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_req;
    logic [31:0] op_a, op_b;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata;
    logic        busy, mult_ack, timeout_err;
    logic [31:0] mul_a, mul_b;
    logic        mul_start;
    logic [63:0] mul_result;
    logic        mul_done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .mult_req   (mult_req),
        .op_a       (op_a),
        .op_b       (op_b),
        .mthi_we    (mthi_we),
        .mtlo_we    (mtlo_we),
        .wdata      (wdata),
        .busy       (busy),
        .mult_ack   (mult_ack),
        .timeout_err(timeout_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .hi         (hi),
        .lo         (lo)
    );

    // Multiplier model: start sampled at an edge, done visible 33 edges later,
    // done stays high until the next start. Not reset by the sequencer.
    logic [5:0]  m_cnt  = 6'd0;
    logic        m_done = 1'b0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;
    logic [63:0] m_prod = 64'd0;
    logic        stub_dead = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_a    <= mul_a;
            m_b    <= mul_b;
            m_cnt  <= 6'd33;
            m_done <= 1'b0;
        end else if (m_cnt != 6'd0) begin
            m_cnt <= m_cnt - 6'd1;
            if (m_cnt == 6'd1) begin
                m_done <= 1'b1;
                m_prod <= $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
            end
        end
    end

    assign mul_result = m_prod;
    assign mul_done   = m_done & ~stub_dead;

    // Issue one request (called at a negedge) and follow it until busy falls.
    // Sample k is taken at the negedge after the k-th edge following acceptance.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int idle_at, output int busy_n, output int start_n,
                            output logic ack_seen, output logic ack_early, output logic err_busy);
        int k;
        op_a = a; op_b = b; mult_req = 1'b1;
        @(negedge clk);
        mult_req = 1'b0;
        k = 0; idle_at = -1; busy_n = 0; start_n = 0;
        ack_seen = 1'b0; ack_early = 1'b0; err_busy = 1'b0;
        while (idle_at < 0 && k < 80) begin
            if (!busy) begin
                idle_at  = k;
                ack_seen = mult_ack;
            end else begin
                busy_n++;
                if (mul_start)   start_n++;
                if (mult_ack)    ack_early = 1'b1;
                if (timeout_err) err_busy  = 1'b1;
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mult_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op_a = '0; op_b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, mult_ack, mul_start, timeout_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {busy, mult_ack, mul_start, timeout_err});
        end
        checks++;
        if ({hi, lo, mul_a, mul_b} !== 128'd0) begin
            failures++; $display("FAIL reset_regs: got hi=%h lo=%h a=%h b=%h want all 0", hi, lo, mul_a, mul_b);
        end
    endtask

    task automatic test_basic_mult();
        int idle_at, busy_n, start_n; logic ack_seen, ack_early, err_busy;
        run_mult(32'd3, 32'hFFFF_FFFE, idle_at, busy_n, start_n, ack_seen, ack_early, err_busy);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            failures++; $display("FAIL mult_3x-2: got %h want FFFFFFFFFFFFFFFA", {hi, lo});
        end
        checks++;
        if (idle_at !== 35 || busy_n !== 35) begin
            failures++; $display("FAIL mult_latency: got idle_at=%0d busy=%0d want 35/35", idle_at, busy_n);
        end
        checks++;
        if (ack_seen !== 1'b1 || ack_early !== 1'b0 || start_n !== 1) begin
            failures++; $display("FAIL mult_handshake: got ack=%b early=%b starts=%0d want 1/0/1", ack_seen, ack_early, start_n);
        end
        @(negedge clk);
        checks++;
        if (mult_ack !== 1'b0) begin
            failures++; $display("FAIL ack_width: got %b want 0 one cycle after ack", mult_ack);
        end
    endtask

    task automatic test_extremes();
        int idle_at, busy_n, start_n; logic ack_seen, ack_early, err_busy;
        run_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, idle_at, busy_n, start_n, ack_seen, ack_early, err_busy);
        checks++;
        if ({hi, lo} !== 64'h3FFF_FFFF_0000_0001 || !ack_seen) begin
            failures++; $display("FAIL mult_maxpos: got %h ack=%b want 3FFFFFFF00000001 ack=1", {hi, lo}, ack_seen);
        end
        @(negedge clk);
        run_mult(32'h8000_0000, 32'hFFFF_FFFF, idle_at, busy_n, start_n, ack_seen, ack_early, err_busy);
        checks++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000 || !ack_seen) begin
            failures++; $display("FAIL mult_minneg: got %h ack=%b want 0000000080000000 ack=1", {hi, lo}, ack_seen);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k; int a_bad;
        op_a = 32'd6; op_b = 32'd7; mult_req = 1'b1;
        @(negedge clk);
        op_a = 32'd100; op_b = 32'hFFFF_FFFD;   // request held with next operands
        k = 0; a_bad = 0;
        while (!mult_ack && k < 80) begin
            if (busy && (mul_a !== 32'd6 || mul_b !== 32'd7)) a_bad++;
            @(negedge clk); k++;
        end
        checks++;
        if ({hi, lo} !== 64'd42 || a_bad !== 0) begin
            failures++; $display("FAIL b2b_first: got %h operand_glitches=%0d want 42/0", {hi, lo}, a_bad);
        end
        @(negedge clk);   // held request accepted; stale done is high during START
        mult_req = 1'b0;
        checks++;
        if (mul_start !== 1'b1 || mul_done !== 1'b1 || mul_a !== 32'd100) begin
            failures++; $display("FAIL b2b_start: got start=%b done=%b a=%h want 1/1/64", mul_start, mul_done, mul_a);
        end
        k = 0;
        while (!mult_ack && k < 80) begin
            @(negedge clk); k++;
        end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FED4 || k !== 35) begin
            failures++; $display("FAIL b2b_second: got %h ack_at=%0d want FFFFFFFFFFFFFED4 at 35", {hi, lo}, k);
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int k; logic [31:0] lo_before;
        mthi_we = 1'b1; wdata = 32'hDEAD_0000;
        @(negedge clk);
        mthi_we = 1'b0;
        checks++;
        if (hi !== 32'hDEAD_0000 || lo !== 32'hFFFF_FED4) begin
            failures++; $display("FAIL mthi_idle: got hi=%h lo=%h want DEAD0000/FFFFFED4", hi, lo);
        end
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL mthilo_both: got hi=%h lo=%h want CAFEF00D both", hi, lo);
        end
        // Move in the same cycle as a request: applied, then overwritten by the product.
        mthi_we = 1'b1; wdata = 32'hABCD_0000; op_a = 32'd2; op_b = 32'd3; mult_req = 1'b1;
        @(negedge clk);
        mthi_we = 1'b0; mult_req = 1'b0;
        checks++;
        if (hi !== 32'hABCD_0000 || busy !== 1'b1) begin
            failures++; $display("FAIL mthi_with_req: got hi=%h busy=%b want ABCD0000/1", hi, busy);
        end
        repeat (5) @(negedge clk);
        lo_before = lo;
        mtlo_we = 1'b1; wdata = 32'h5555_5555;
        @(negedge clk);
        mtlo_we = 1'b0;
        checks++;
        if (lo !== lo_before || lo !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL mtlo_busy: got lo=%h want CAFEF00D", lo);
        end
        k = 0;
        while (!mult_ack && k < 80) begin
            @(negedge clk); k++;
        end
        checks++;
        if ({hi, lo} !== 64'd6) begin
            failures++; $display("FAIL mthi_overwrite: got %h want 6", {hi, lo});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int idle_at, busy_n, start_n; logic ack_seen, ack_early, err_busy;
        stub_dead = 1'b1;
        run_mult(32'd9, 32'd9, idle_at, busy_n, start_n, ack_seen, ack_early, err_busy);
        checks++;
        if (idle_at !== 41 || ack_seen !== 1'b0 || ack_early !== 1'b0) begin
            failures++; $display("FAIL timeout_exit: got idle_at=%0d ack=%b/%b want 41/0/0", idle_at, ack_seen, ack_early);
        end
        checks++;
        if (timeout_err !== 1'b1 || err_busy !== 1'b0) begin
            failures++; $display("FAIL timeout_err: got err=%b err_while_busy=%b want 1/0", timeout_err, err_busy);
        end
        checks++;
        if ({hi, lo} !== 64'd6) begin
            failures++; $display("FAIL timeout_hilo: got %h want 6 (unchanged)", {hi, lo});
        end
        // Releasing the stub leaves done high while idle: must be ignored; error stays sticky.
        stub_dead = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || mult_ack !== 1'b0 || {hi, lo} !== 64'd6) begin
            failures++; $display("FAIL timeout_sticky: got err=%b ack=%b hilo=%h want 1/0/6", timeout_err, mult_ack, {hi, lo});
        end
    endtask

    task automatic test_reset_mid_wait();
        int idle_at, busy_n, start_n; logic ack_seen, ack_early, err_busy;
        op_a = 32'd9; op_b = 32'd9; mult_req = 1'b1;
        @(negedge clk);
        mult_req = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0 || timeout_err !== 1'b0 || mul_a !== 32'd0) begin
            failures++; $display("FAIL reset_mid_wait: got busy=%b hilo=%h err=%b a=%h want 0", busy, {hi, lo}, timeout_err, mul_a);
        end
        reset = 1'b0;
        @(negedge clk);
        run_mult(32'd5, 32'd7, idle_at, busy_n, start_n, ack_seen, ack_early, err_busy);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd35 || idle_at !== 35 || !ack_seen) begin
            failures++; $display("FAIL after_reset_mult: got hi=%h lo=%h idle_at=%0d ack=%b want 0/23/35/1", hi, lo, idle_at, ack_seen);
        end
    endtask

    initial begin
        reset = 1'b1; mult_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op_a = '0; op_b = '0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic_mult();
        test_extremes();
        test_back_to_back();
        test_mthi_mtlo();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
